// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags; used by the arbiter to hold read tags.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrBits = $clog2(DEPTH);
  localparam logic [PtrBits:0] PtrOne = {{PtrBits{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrBits:0] r_wr_ptr;
  logic [PtrBits:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[PtrBits] != r_rd_ptr[PtrBits]) &&
                      (r_wr_ptr[PtrBits-1:0] == r_rd_ptr[PtrBits-1:0]);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr[PtrBits-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PtrBits-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of one SRAM controller; read data is steered back
// to the issuing port using an in-order tag FIFO.
module sram_arbiter #(
  parameter int unsigned ADDR_BITS = 20,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_write_enable,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [DATA_BITS-1:0] p0_write_data,
  output logic                 p0_grant,
  output logic [DATA_BITS-1:0] p0_read_data,
  output logic                 p0_read_data_valid,
  input  logic                 p1_req,
  input  logic                 p1_write_enable,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [DATA_BITS-1:0] p1_write_data,
  output logic                 p1_grant,
  output logic [DATA_BITS-1:0] p1_read_data,
  output logic                 p1_read_data_valid,
  output logic                 ctrl_req,
  input  logic                 ctrl_ready,
  output logic                 ctrl_write_enable,
  output logic [ADDR_BITS-1:0] ctrl_addr,
  output logic [DATA_BITS-1:0] ctrl_write_data,
  input  logic [DATA_BITS-1:0] ctrl_read_data,
  input  logic                 ctrl_read_data_valid,
  output logic                 tag_error
);

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  logic r_last_grant;
  logic r_tag_error;
  logic w_elig0;
  logic w_elig1;
  logic w_sel;
  logic w_issue;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_pop_ok;

  // A read is ineligible while the tag FIFO is full, even if a pop frees a slot this cycle.
  always_comb begin
    w_elig0 = p0_req && (p0_write_enable || !w_full);
    w_elig1 = p1_req && (p1_write_enable || !w_full);
    w_sel   = Port0;
    if (w_elig0 && w_elig1) begin
      w_sel = ~r_last_grant;
    end else if (w_elig1) begin
      w_sel = Port1;
    end
    w_issue = !reset && ctrl_ready && (w_elig0 || w_elig1);
  end

  always_comb begin
    ctrl_write_enable = p0_write_enable;
    ctrl_addr         = p0_addr;
    ctrl_write_data   = p0_write_data;
    if (w_sel == Port1) begin
      ctrl_write_enable = p1_write_enable;
      ctrl_addr         = p1_addr;
      ctrl_write_data   = p1_write_data;
    end
  end

  assign ctrl_req = w_issue;
  assign p0_grant = w_issue && (w_sel == Port0);
  assign p1_grant = w_issue && (w_sel == Port1);
  assign w_push   = w_issue && !ctrl_write_enable;
  assign w_pop_ok = ctrl_read_data_valid && !w_empty;

  assign p0_read_data       = ctrl_read_data;
  assign p1_read_data       = ctrl_read_data;
  assign p0_read_data_valid = w_pop_ok && (w_head == Port0);
  assign p1_read_data_valid = w_pop_ok && (w_head == Port1);
  assign tag_error          = r_tag_error;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_sel),
    .i_pop       (ctrl_read_data_valid),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Port 1 is "last" out of reset so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= Port1;
      r_tag_error  <= 1'b0;
    end else begin
      if (w_issue) r_last_grant <= w_sel;
      if (ctrl_read_data_valid && w_empty) r_tag_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM controller model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_write_enable, p0_grant, p0_read_data_valid;
  logic [19:0] p0_addr;
  logic [15:0] p0_write_data, p0_read_data;
  logic        p1_req, p1_write_enable, p1_grant, p1_read_data_valid;
  logic [19:0] p1_addr;
  logic [15:0] p1_write_data, p1_read_data;
  logic        ctrl_req, ctrl_ready, ctrl_write_enable, ctrl_read_data_valid;
  logic [19:0] ctrl_addr;
  logic [15:0] ctrl_write_data, ctrl_read_data;
  logic        tag_error;

  logic        m_ready;
  logic        vpipe [16];
  logic [15:0] dpipe [16];
  logic [15:0] mem [4096];
  logic        inj;
  logic [15:0] inj_data;
  int          lat;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .p0_req               (p0_req),
    .p0_write_enable      (p0_write_enable),
    .p0_addr              (p0_addr),
    .p0_write_data        (p0_write_data),
    .p0_grant             (p0_grant),
    .p0_read_data         (p0_read_data),
    .p0_read_data_valid   (p0_read_data_valid),
    .p1_req               (p1_req),
    .p1_write_enable      (p1_write_enable),
    .p1_addr              (p1_addr),
    .p1_write_data        (p1_write_data),
    .p1_grant             (p1_grant),
    .p1_read_data         (p1_read_data),
    .p1_read_data_valid   (p1_read_data_valid),
    .ctrl_req             (ctrl_req),
    .ctrl_ready           (ctrl_ready),
    .ctrl_write_enable    (ctrl_write_enable),
    .ctrl_addr            (ctrl_addr),
    .ctrl_write_data      (ctrl_write_data),
    .ctrl_read_data       (ctrl_read_data),
    .ctrl_read_data_valid (ctrl_read_data_valid),
    .tag_error            (tag_error)
  );

  // Controller model: ready drops for one cycle after each accept; reads return after lat cycles.
  assign ctrl_ready           = m_ready;
  assign ctrl_read_data_valid = vpipe[0] | inj;
  assign ctrl_read_data       = inj ? inj_data : dpipe[0];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        vpipe[i] <= 1'b0;
        dpipe[i] <= 16'h0;
      end
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
      mem[12'h010] <= 16'hA5A5;
      mem[12'h100] <= 16'h1111;
      mem[12'h200] <= 16'h2222;
      mem[12'h300] <= 16'h3333;
    end else begin
      m_ready <= !ctrl_req;
      if (ctrl_req && ctrl_write_enable) mem[ctrl_addr[11:0]] <= ctrl_write_data;
      for (int i = 0; i < 16; i++) begin
        if (ctrl_req && !ctrl_write_enable && i == lat - 1) begin
          vpipe[i] <= 1'b1;
          dpipe[i] <= mem[ctrl_addr[11:0]];
        end else if (i < 15) begin
          vpipe[i] <= vpipe[i+1];
          dpipe[i] <= dpipe[i+1];
        end else begin
          vpipe[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ret(input string tag);
    int i = 0;
    while (ctrl_read_data_valid !== 1'b1 && i < 40) begin
      tick();
      #1;
      i++;
    end
    chk({tag, "_timeout"}, 32'(ctrl_read_data_valid), 1);
  endtask

  initial begin
    reset = 1'b1; inj = 1'b0; inj_data = 16'h0; lat = 3;
    p0_req = 1'b0; p0_write_enable = 1'b0; p0_addr = '0; p0_write_data = '0;
    p1_req = 1'b0; p1_write_enable = 1'b0; p1_addr = '0; p1_write_data = '0;

    // Reset state: no issue while reset is high even with a request.
    tick(); p0_req = 1'b1; #1;
    chk("rst_ctrl_req", 32'(ctrl_req), 0);
    chk("rst_p0_grant", 32'(p0_grant), 0);
    chk("rst_tag_error", 32'(tag_error), 0);
    chk("rst_valids", 32'({p0_read_data_valid, p1_read_data_valid}), 0);
    p0_req = 1'b0;
    tick(); reset = 1'b0; #1;

    // Single read.
    tick(); p0_req = 1'b1; p0_write_enable = 1'b0; p0_addr = 20'h00010; #1;
    chk("t1_p0_grant", 32'(p0_grant), 1);
    chk("t1_p1_grant", 32'(p1_grant), 0);
    chk("t1_ctrl_req", 32'(ctrl_req), 1);
    chk("t1_ctrl_addr", 32'(ctrl_addr), 32'h10);
    chk("t1_ctrl_we", 32'(ctrl_write_enable), 0);
    tick(); p0_req = 1'b0; #1;
    wait_ret("t1");
    chk("t1_p0_valid", 32'(p0_read_data_valid), 1);
    chk("t1_p1_valid", 32'(p1_read_data_valid), 0);
    chk("t1_p0_data", 32'(p0_read_data), 32'hA5A5);
    tick(); #1;
    chk("t1_valid_pulse", 32'(p0_read_data_valid), 0);

    // Contention from reset: p0, -, p1, -, p0, -, p1, -.
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    p0_req = 1'b1; p0_write_enable = 1'b1; p0_addr = 20'h00001; p0_write_data = 16'h0A0A;
    p1_req = 1'b1; p1_write_enable = 1'b1; p1_addr = 20'h00002; p1_write_data = 16'h0B0B;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t2_p0_grant_c%0d", c), 32'(p0_grant), 32'(c % 4 == 0));
      chk($sformatf("t2_p1_grant_c%0d", c), 32'(p1_grant), 32'(c % 4 == 2));
      tick(); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // Interleaved reads return in issue order.
    tick();
    p0_req = 1'b1; p0_write_enable = 1'b0; p0_addr = 20'h00100;
    p1_req = 1'b1; p1_write_enable = 1'b0; p1_addr = 20'h00200;
    #1;
    chk("t3_p0_first", 32'({p0_grant, p1_grant}), 32'b10);
    tick(); p0_req = 1'b0; #1;
    chk("t3_ready_gap", 32'(p1_grant), 0);
    tick(); #1;
    chk("t3_p1_second", 32'(p1_grant), 1);
    tick(); p1_req = 1'b0; #1;
    wait_ret("t3a");
    chk("t3_ret0_ports", 32'({p0_read_data_valid, p1_read_data_valid}), 32'b10);
    chk("t3_ret0_data", 32'(p0_read_data), 32'h1111);
    tick(); #1;
    wait_ret("t3b");
    chk("t3_ret1_ports", 32'({p0_read_data_valid, p1_read_data_valid}), 32'b01);
    chk("t3_ret1_data", 32'(p1_read_data), 32'h2222);

    // Tag FIFO full with 12-cycle read latency.
    lat = 12;
    tick(); p0_req = 1'b1; p0_write_enable = 1'b0; p0_addr = 20'h00300; #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t4_p0_grant_c%0d", c), 32'(p0_grant), 32'(c % 2 == 0));
      tick(); #1;
    end
    p1_req = 1'b1; p1_write_enable = 1'b1; p1_addr = 20'h00400; p1_write_data = 16'h5555; #1;
    chk("t4_full_write_ok", 32'({p0_grant, p1_grant}), 32'b01);
    tick(); p1_req = 1'b0; #1;
    chk("t4_c9_p0_grant", 32'(p0_grant), 0);
    tick(); #1;
    chk("t4_full_block", 32'({ctrl_ready, ctrl_req}), 32'b10);
    tick(); #1;
    chk("t4_c11_p0_grant", 32'(p0_grant), 0);
    tick(); #1;
    chk("t4_pop_p0_valid", 32'({p0_read_data_valid, p1_read_data_valid}), 32'b10);
    chk("t4_pop_no_issue", 32'(p0_grant), 0);
    tick(); #1;
    chk("t4_after_pop_grant", 32'(p0_grant), 1);
    tick(); p0_req = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      wait_ret($sformatf("t4_drain%0d", k));
      chk($sformatf("t4_drain%0d_port", k), 32'({p0_read_data_valid, p1_read_data_valid}),
          32'b10);
      chk($sformatf("t4_drain%0d_data", k), 32'(p0_read_data), 32'h3333);
      tick(); #1;
    end
    lat = 3;

    // Write passthrough, then read back.
    chk("t5_tag_error_clear", 32'(tag_error), 0);
    tick();
    p1_req = 1'b1; p1_write_enable = 1'b1; p1_addr = 20'h0ABCD; p1_write_data = 16'hBEEF; #1;
    chk("t5_p1_grant", 32'(p1_grant), 1);
    chk("t5_ctrl_we", 32'(ctrl_write_enable), 1);
    chk("t5_ctrl_addr", 32'(ctrl_addr), 32'h0ABCD);
    chk("t5_ctrl_wdata", 32'(ctrl_write_data), 32'hBEEF);
    tick(); p1_req = 1'b0;
    p0_req = 1'b1; p0_write_enable = 1'b0; p0_addr = 20'h0ABCD; #1;
    chk("t5_ready_gap", 32'(p0_grant), 0);
    tick(); #1;
    chk("t5_p0_grant", 32'(p0_grant), 1);
    tick(); p0_req = 1'b0; #1;
    wait_ret("t5");
    chk("t5_p0_valid", 32'(p0_read_data_valid), 1);
    chk("t5_p0_data", 32'(p0_read_data), 32'hBEEF);

    // Stray valid with empty FIFO (the write pushed no tag).
    tick(); inj = 1'b1; inj_data = 16'hDEAD; #1;
    chk("t6_stray_no_valid", 32'({p0_read_data_valid, p1_read_data_valid}), 0);
    tick(); inj = 1'b0; #1;
    chk("t6_tag_error_set", 32'(tag_error), 1);
    tick(); #1;
    chk("t6_tag_error_sticky", 32'(tag_error), 1);

    // Reset in the middle of an outstanding read.
    p0_req = 1'b1; p0_write_enable = 1'b0; p0_addr = 20'h00010; #1;
    chk("t6_read_grant", 32'(p0_grant), 1);
    tick(); p0_req = 1'b0;
    p1_req = 1'b1; p1_write_enable = 1'b1; p1_addr = 20'h00400; reset = 1'b1; #1;
    chk("t6_rst_ctrl_req", 32'(ctrl_req), 0);
    chk("t6_rst_p1_grant", 32'(p1_grant), 0);
    chk("t6_rst_tag_error", 32'(tag_error), 0);
    tick(); #1;
    chk("t6_rst_hold_req", 32'(ctrl_req), 0);
    reset = 1'b0; p1_req = 1'b0;
    tick(); inj = 1'b1; inj_data = 16'h1234; #1;
    chk("t6_fifo_cleared", 32'({p0_read_data_valid, p1_read_data_valid}), 0);
    tick(); inj = 1'b0; #1;
    chk("t6_post_rst_error", 32'(tag_error), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter sharing one `sram_controller` between two requesters (e.g. a display scan-out reader and a pixel writer). Each port sees the controller's own req/ready/addr/data handshake. The arbiter tracks which port issued each outstanding read and steers returned read data back to that port in order.

## Interface
Parameters:
- `ADDR_BITS`, 20, SRAM address width
- `DATA_BITS`, 16, SRAM data width
- `TAG_DEPTH`, 4, maximum outstanding reads (power of two, ≥2)

Ports (`N` ∈ {0,1}; one set per requester):
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `pN_req`  in  1  requester N wants an access; holds until granted
- `pN_write_enable`  in  1  1 = write, 0 = read
- `pN_addr`  in  ADDR_BITS  access address
- `pN_write_data`  in  DATA_BITS  write payload
- `pN_grant`  out  1  one-cycle pulse: request accepted this cycle
- `pN_read_data`  out  DATA_BITS  returned read word (shared bus, qualified by valid)
- `pN_read_data_valid`  out  1  one-cycle pulse: `pN_read_data` holds N's read result
- `ctrl_req`  out  1  to controller `req`
- `ctrl_ready`  in  1  from controller `ready`
- `ctrl_write_enable`  out  1  to controller
- `ctrl_addr`  out  ADDR_BITS  to controller
- `ctrl_write_data`  out  DATA_BITS  to controller
- `ctrl_read_data`  in  DATA_BITS  from controller
- `ctrl_read_data_valid`  in  1  from controller
- `tag_error`  out  1  sticky: read data returned with no outstanding tag

## Operation
- Issue condition: `ctrl_ready && (p0_req || p1_req) && !(selected op is read && tag FIFO full)`; `ctrl_req` is 1 only in that cycle.
- Selection: both requesting → port ≠ `last_grant`; one requesting → that port. `last_grant` updates to the issued port on every issue.
- Mux: `ctrl_write_enable/addr/write_data` driven combinationally from the selected port; when nothing is selected, port 0's values (don't care).
- `pN_grant` = `ctrl_req` and N selected. Requester drops or changes its request only after seeing grant.
- Read issue pushes port index (1 bit) into the tag FIFO. Writes push nothing.
- `ctrl_read_data_valid` pops the head tag; the matching `pN_read_data_valid` pulses the same cycle. `p0_read_data = p1_read_data = ctrl_read_data`.
- Valid with empty FIFO: no port valid, `tag_error` set and held until reset.
- Full FIFO: a read is not issued, even if a pop occurs that cycle; a write from the other port may still issue (round-robin still applies among eligible ports).
- Push and pop in the same cycle (not full): both take effect; count unchanged.

## Timing
- Reset values: `last_grant`=1, so port 0 wins the first tie. FIFO empty, `tag_error`=0, all grants and valids 0. `ctrl_req` is forced to 0 while `reset` is high.
- Grant latency: 0 cycles from `pN_req` when `ctrl_ready`=1. The controller drops ready for one cycle, giving a peak of one issue per 2 cycles.
- Read return latency: `ctrl_read_data_valid` to `pN_read_data_valid` is 0 cycles, purely combinational. The arbiter is agnostic to the controller's pipeline depth.
- Reset mid-operation: the FIFO clears immediately. Any later stray controller valid sets `tag_error`; the system must reset the controller together with the arbiter.

## Structure
- No shared package; all widths come from parameters, port indices are localparams.
- Sub-module `sync_fifo` (WIDTH=1, DEPTH=`TAG_DEPTH`, async active-high reset, `full`/`empty` flags) holds the tags.
- Arbitration, mux and `tag_error` stay in the top module.

## Test plan
- Single read: reset, p0 read addr 0x00010 → `p0_grant` same cycle, later `p0_read_data_valid`=1 with the model's data, `p1_read_data_valid` stays 0.
- Contention: p0 and p1 both request from reset → grants in order p0, p1, p0, p1, each ≥2 cycles apart while both remain requesting.
- Interleaved reads: p0 reads 0x00100, p1 reads 0x00200 back to back → valids return in order p0 then p1 with words 0x1111 and 0x2222 preloaded.
- Tag full: controller model with 12-cycle read latency, p0 streams reads → at most 4 outstanding, no grant while full. A write on p1 still granted.
- Write passthrough: p1 writes 0xBEEF to 0x0ABCD, then p0 reads 0x0ABCD → `p0_read_data`=0xBEEF, no tag pushed for the write.
- Error and reset: inject `ctrl_read_data_valid` with FIFO empty → `tag_error`=1, no port valid. Assert `reset` mid-read → FIFO empty, `tag_error`=0, `ctrl_req`=0.
